// File: rtl/fpga_cfg_pkg.sv
// Shared types and default geometry for the fabric configuration loader.
package fpga_cfg_pkg;

   localparam int N_LUT     = 9;
   localparam int LUT_W     = 33;
   localparam int N_SB      = 13;
   localparam int SB_W      = 16;
   localparam int WORD_W    = 32;
   localparam int CFG_WORDS = 2*N_LUT + N_SB;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LUT_LO = 3'd1,
      LUT_HI = 3'd2,
      SB     = 3'd3,
      CHK    = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } cfg_state_e;

   // Tile index counter width: wide enough for the larger of the two tile arrays.
   function automatic int idx_width(input int n_lut, input int n_sb);
      int m;
      int w;
      m = (n_lut > n_sb) ? n_lut : n_sb;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cfg_onehot_dec.sv
// Index-to-one-hot write strobe decoder; all zeros when not enabled.
module cfg_onehot_dec #(
   parameter int N  = 9,
   parameter int IW = 4
) (
   input  logic [IW-1:0] idx_i,
   input  logic          en_i,
   output logic [N-1:0]  oh_o
);

   // One comparator per tile so at most one bit can ever be set.
   for (genvar g = 0; g < N; g++) begin : g_bit
      assign oh_o[g] = en_i && (idx_i == IW'(g));
   end

endmodule

// File: rtl/fpga_config_loader.sv
// Streams the bitstream into LUT (two words each) and switch-box (one word each)
// config registers, holding the user fabric disabled while loading.
// Optional feature macro: CFG_CHECKSUM_EN -- adds a trailing checksum word that
// must equal the mod-2^WORD_W sum of all data words, else the loader ends in ERR.
module fpga_config_loader #(
   parameter int N_LUT  = fpga_cfg_pkg::N_LUT,
   parameter int LUT_W  = fpga_cfg_pkg::LUT_W,
   parameter int N_SB   = fpga_cfg_pkg::N_SB,
   parameter int SB_W   = fpga_cfg_pkg::SB_W,
   parameter int WORD_W = fpga_cfg_pkg::WORD_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic [N_LUT-1:0]  lut_we,
   output logic [LUT_W-1:0]  lut_data,
   output logic [N_SB-1:0]   sb_we,
   output logic [SB_W-1:0]   sb_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              fabric_en
);
   import fpga_cfg_pkg::*;

   localparam int IW = idx_width(N_LUT, N_SB);

   cfg_state_e        state_q;
   logic [IW-1:0]     idx_q;
   logic [WORD_W-1:0] lo_q;
   logic [N_LUT-1:0]  lut_we_q, lut_we_d;
   logic [LUT_W-1:0]  lut_data_q;
   logic [N_SB-1:0]   sb_we_q, sb_we_d;
   logic [SB_W-1:0]   sb_data_q;
   logic              busy_q, done_q, error_q, fabric_en_q;
   logic              xfer, idx_lut_last, idx_sb_last;
`ifdef CFG_CHECKSUM_EN
   logic [WORD_W-1:0] sum_q;
`endif

   // Ready is a pure decode of the state register, never of cfg_valid.
   assign cfg_ready    = (state_q == LUT_LO) || (state_q == LUT_HI) ||
                         (state_q == SB)     || (state_q == CHK);
   assign xfer         = cfg_valid && cfg_ready;
   assign idx_lut_last = (idx_q == IW'(N_LUT-1));
   assign idx_sb_last  = (idx_q == IW'(N_SB-1));

   cfg_onehot_dec #(.N(N_LUT), .IW(IW)) u_lut_dec (
      .idx_i (idx_q),
      .en_i  (xfer && (state_q == LUT_HI)),
      .oh_o  (lut_we_d)
   );

   cfg_onehot_dec #(.N(N_SB), .IW(IW)) u_sb_dec (
      .idx_i (idx_q),
      .en_i  (xfer && (state_q == SB)),
      .oh_o  (sb_we_d)
   );

   // Load sequencer with registered strobes, data and status outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         lo_q        <= '0;
         lut_we_q    <= '0;
         lut_data_q  <= '0;
         sb_we_q     <= '0;
         sb_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         fabric_en_q <= 1'b0;
`ifdef CFG_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         // Strobes follow the decoders every cycle, so they are single-cycle pulses.
         lut_we_q <= lut_we_d;
         sb_we_q  <= sb_we_d;
         case (state_q)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state_q     <= LUT_LO;
                  idx_q       <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  error_q     <= 1'b0;
                  fabric_en_q <= 1'b0;
`ifdef CFG_CHECKSUM_EN
                  sum_q       <= '0;
`endif
               end
            end
            LUT_LO: begin
               if (xfer) begin
                  lo_q    <= cfg_data;
                  state_q <= LUT_HI;
               end
            end
            LUT_HI: begin
               if (xfer) begin
                  lut_data_q <= {cfg_data[LUT_W-WORD_W-1:0], lo_q};
                  if (idx_lut_last) begin
                     idx_q   <= '0;
                     state_q <= SB;
                  end else begin
                     idx_q   <= idx_q + IW'(1);
                     state_q <= LUT_LO;
                  end
               end
            end
            SB: begin
               if (xfer) begin
                  sb_data_q <= cfg_data[SB_W-1:0];
                  if (idx_sb_last) begin
                     idx_q <= '0;
`ifdef CFG_CHECKSUM_EN
                     state_q <= CHK;
`else
                     state_q     <= DONE;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     fabric_en_q <= 1'b1;
`endif
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end
            end
`ifdef CFG_CHECKSUM_EN
            CHK: begin
               if (xfer) begin
                  busy_q <= 1'b0;
                  if (cfg_data == sum_q) begin
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     fabric_en_q <= 1'b1;
                  end else begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
`ifdef CFG_CHECKSUM_EN
         // Every data word contributes to the running sum; the trailer does not.
         if (xfer && (state_q != CHK)) sum_q <= sum_q + cfg_data;
`endif
      end
   end

   assign lut_we    = lut_we_q;
   assign lut_data  = lut_data_q;
   assign sb_we     = sb_we_q;
   assign sb_data   = sb_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fabric_en = fabric_en_q;
`ifdef CFG_CHECKSUM_EN
   assign error     = error_q;
`else
   assign error     = 1'b0;
`endif

endmodule
